stage_buffer: RTL and testbench

Parametrised elastic pipeline buffer placed between CPU pipeline stages (IF-ID, ID-EX, EX-MEM, MEM-WB). It generalises the fixed single-register stage latch to DEPTH entries of any payload WIDTH and adds a valid/ready handshake, flush, and a programmable bubble value. Stages pass their packed stage bus as a flat vector, so one module serves every stage boundary. Stall results from backpressure on `out_ready`, and squash results from `flush`.

---
 rtl/stage_buffer_pkg.sv | 41 ++++
 rtl/stage_buffer_ram.sv | 19 +
 rtl/stage_buffer.sv | 87 ++++++++
 tb/tb_stage_buffer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_buffer_pkg.sv
// CPU_buffer_bus: shared stage bus types, their widths and the stage_buffer count-width helper.
package CPU_buffer_bus;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic [31:0] instr;
   } if_id_bus_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [7:0]  ctrl;
   } id_ex_bus_t;

   typedef struct packed {
      logic [31:0] alu_res;
      logic [31:0] rs2_val;
      logic [4:0]  rd;
      logic [7:0]  ctrl;
   } ex_mem_bus_t;

   typedef struct packed {
      logic [31:0] wb_data;
      logic [4:0]  rd;
      logic        reg_we;
   } mem_wb_bus_t;

   localparam int unsigned IF_ID_W  = $bits(if_id_bus_t);
   localparam int unsigned ID_EX_W  = $bits(id_ex_bus_t);
   localparam int unsigned EX_MEM_W = $bits(ex_mem_bus_t);
   localparam int unsigned MEM_WB_W = $bits(mem_wb_bus_t);

   function automatic int unsigned stage_buffer_cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/stage_buffer_ram.sv
// stage_buffer_ram: DEPTH x WIDTH register array, one write port, one asynchronous read port, no reset.
module stage_buffer_ram #(
   parameter int unsigned WIDTH = 96,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned PTR_W = 1
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end
   assign rdata = mem[raddr];
endmodule

// File: rtl/stage_buffer.sv
// stage_buffer: elastic valid/ready pipeline buffer with flush and bubble value.
// Define STAGE_BUFFER_BYPASS_EN for a zero-latency pass-through when the buffer is empty.
module stage_buffer
   import CPU_buffer_bus::*;
#(
   parameter int unsigned      WIDTH  = 96,
   parameter int unsigned      DEPTH  = 2,
   parameter logic [WIDTH-1:0] BUBBLE = '0
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  flush,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [WIDTH-1:0]                      in_data,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [WIDTH-1:0]                      out_data,
   output logic [stage_buffer_cnt_w(DEPTH)-1:0]  count
);
   localparam int unsigned      CNT_W = stage_buffer_cnt_w(DEPTH);
   localparam int unsigned      PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] rd_data;
   logic             stored, bypass_take, wr_en, rd_en;

   assign stored   = (count_q != '0);
   assign in_ready = !rst && (count_q != CNT_W'(DEPTH));
   assign count    = count_q;

`ifdef STAGE_BUFFER_BYPASS_EN
   logic bypass;
   assign bypass      = !stored && !flush;
   assign out_valid   = stored || (bypass && in_valid);
   assign out_data    = stored ? rd_data : (bypass && in_valid) ? in_data : BUBBLE;
   assign bypass_take = bypass && in_valid && out_ready;
`else
   assign out_valid   = stored;
   assign out_data    = stored ? rd_data : BUBBLE;
   assign bypass_take = 1'b0;
`endif

   // A bypassed item goes straight downstream and never occupies storage.
   assign wr_en = in_valid && in_ready && !flush && !bypass_take;
   assign rd_en = stored && out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         wr_ptr_d = wr_en ? ((wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
         rd_ptr_d = rd_en ? ((rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
         count_d  = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   stage_buffer_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr_q),
      .wdata (in_data),
      .raddr (rd_ptr_q),
      .rdata (rd_data)
   );

   assert property (@(posedge clk) disable iff (rst) count_q <= CNT_W'(DEPTH));
endmodule

// File: tb/tb_stage_buffer.sv
// tb_stage_buffer: drives DEPTH=2 and DEPTH=3 buffers with shared inputs against queue models.
module tb_stage_buffer;
`ifdef STAGE_BUFFER_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic       clk, rst, flush, in_valid, out_ready;
   logic [7:0] in_data;
   logic       ir [2];
   logic       ov [2];
   logic [7:0] od [2];
   logic [1:0] cnt [2];

   int         dep [2] = '{2, 3};
   logic [7:0] q [2][$];
   logic [7:0] seen [2][$];
   int         errors = 0;
   int         checks = 0;

   stage_buffer #(.WIDTH(8), .DEPTH(2), .BUBBLE(8'h00)) dut2 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
      .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .count(cnt[0]));
   stage_buffer #(.WIDTH(8), .DEPTH(3), .BUBBLE(8'h00)) dut3 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
      .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .count(cnt[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1);
   end

   function automatic logic e_rdy(int k);
      return !rst && (q[k].size() < dep[k]);
   endfunction

   function automatic logic e_valid(int k);
      return (q[k].size() != 0) || (BYP && !flush && in_valid);
   endfunction

   function automatic logic [7:0] e_data(int k);
      return (q[k].size() != 0) ? q[k][0] : (BYP && !flush && in_valid) ? in_data : 8'h00;
   endfunction

   function automatic logic [11:0] exp_vec(int k);
      return {e_rdy(k), e_valid(k), e_data(k), 2'(q[k].size())};
   endfunction

   function automatic logic [11:0] act_vec(int k);
      return {ir[k], ov[k], od[k], cnt[k]};
   endfunction

   // Advance one clock: record what the DUTs hand downstream, then apply the queue rules.
   task automatic cyc();
      int sz;
      bit take;
      for (int k = 0; k < 2; k++) begin
         if (ov[k] === 1'b1 && out_ready && !rst) seen[k].push_back(od[k]);
         sz   = q[k].size();
         take = BYP && sz == 0 && !flush && in_valid && out_ready;
         if (rst || flush) q[k].delete();
         else if (!take) begin
            if (sz != 0 && out_ready) void'(q[k].pop_front());
            if (in_valid && sz < dep[k]) q[k].push_back(in_data);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; flush = 0; in_valid = 1; in_data = 8'h99; out_ready = 0;
      #1;
      for (int c = 0; c < 2; c++) begin
         cyc();
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (ir[k] !== 1'b0) begin
               errors++;
               $display("FAIL reset_in_ready dut%0d got=%b exp=0", k, ir[k]);
            end
         end
      end
      rst = 0; in_valid = 0;
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (act_vec(k) !== {1'b1, 1'b0, 8'h00, 2'd0}) begin
            errors++;
            $display("FAIL reset_state dut%0d got=%h exp=%h", k, act_vec(k), {1'b1, 1'b0, 8'h00, 2'd0});
         end
      end
   endtask

   task automatic test_fill_drain();
      out_ready = 0; in_valid = 1; in_data = 8'hA1;
      #1; cyc();
      in_data = 8'hB2;
      #1; cyc();
      in_data = 8'hC3;
      #1;
      checks++;
      if ({cnt[0], ir[0], od[0]} !== {2'd2, 1'b0, 8'hA1}) begin
         errors++;
         $display("FAIL fill_full got cnt=%0d rdy=%b data=%h exp cnt=2 rdy=0 data=a1", cnt[0], ir[0], od[0]);
      end
      cyc();
      in_valid = 0; out_ready = 1;
      #1;
      checks++;
      if (od[0] !== 8'hA1 || cnt[0] !== 2'd2) begin
         errors++;
         $display("FAIL fill_c3_rejected got data=%h cnt=%0d exp data=a1 cnt=2", od[0], cnt[0]);
      end
      cyc();
      checks++;
      if (od[0] !== 8'hB2 || ov[0] !== 1'b1) begin
         errors++;
         $display("FAIL drain_second got v=%b data=%h exp v=1 data=b2", ov[0], od[0]);
      end
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (act_vec(k) !== exp_vec(k)) begin
            errors++;
            $display("FAIL drain_vec dut%0d got=%h exp=%h", k, act_vec(k), exp_vec(k));
         end
      end
      cyc();
      checks++;
      if (ov[0] !== 1'b0 || od[0] !== 8'h00) begin
         errors++;
         $display("FAIL drain_empty got v=%b data=%h exp v=0 data=00", ov[0], od[0]);
      end
      cyc();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (act_vec(k) !== exp_vec(k)) begin
            errors++;
            $display("FAIL drain_final dut%0d got=%h exp=%h", k, act_vec(k), exp_vec(k));
         end
      end
   endtask

   task automatic test_stream();
      seen[0].delete(); seen[1].delete();
      in_valid = 1; out_ready = 1;
      for (int i = 1; i <= 8; i++) begin
         in_data = 8'(i);
         #1;
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (act_vec(k) !== exp_vec(k)) begin
               errors++;
               $display("FAIL stream_vec dut%0d step%0d got=%h exp=%h", k, i, act_vec(k), exp_vec(k));
            end
         end
         checks++;
         if (cnt[0] > 2'd1) begin
            errors++;
            $display("FAIL stream_count got=%0d exp<=1", cnt[0]);
         end
         cyc();
      end
      in_valid = 0;
      #1; cyc(); cyc();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (seen[k].size() != 8) begin
            errors++;
            $display("FAIL stream_len dut%0d got=%0d exp=8", k, seen[k].size());
         end else begin
            for (int i = 0; i < 8; i++) begin
               checks++;
               if (seen[k][i] !== 8'(i + 1)) begin
                  errors++;
                  $display("FAIL stream_order dut%0d idx%0d got=%h exp=%h", k, i, seen[k][i], 8'(i + 1));
               end
            end
         end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] pushed [$];
      int n = 0;
      int c = 0;
      seen[0].delete(); seen[1].delete();
      while ((n < 10 || q[1].size() != 0) && c < 200) begin
         in_valid  = (n < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
         in_data   = 8'($urandom);
         out_ready = (n < 10) ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (act_vec(k) !== exp_vec(k)) begin
               errors++;
               $display("FAIL wrap_vec dut%0d cyc%0d got=%h exp=%h", k, c, act_vec(k), exp_vec(k));
            end
         end
         if (in_valid && e_rdy(1)) begin
            pushed.push_back(in_data);
            n++;
         end
         cyc();
         c++;
      end
      in_valid = 0; out_ready = 1;
      #1; cyc(); cyc();
      checks++;
      if (c >= 200 || seen[1].size() != pushed.size()) begin
         errors++;
         $display("FAIL wrap_len got=%0d exp=%0d cycles=%0d", seen[1].size(), pushed.size(), c);
      end else begin
         for (int i = 0; i < pushed.size(); i++) begin
            checks++;
            if (seen[1][i] !== pushed[i]) begin
               errors++;
               $display("FAIL wrap_order idx%0d got=%h exp=%h", i, seen[1][i], pushed[i]);
            end
         end
      end
   endtask

   task automatic test_flush();
      out_ready = 0; in_valid = 1; in_data = 8'h11;
      #1; cyc();
      in_data = 8'h22;
      #1; cyc();
      checks++;
      if (cnt[0] !== 2'd2) begin
         errors++;
         $display("FAIL flush_pre_count got=%0d exp=2", cnt[0]);
      end
      flush = 1; in_data = 8'h55;
      #1; cyc();
      flush = 0; in_valid = 0;
      #1;
      checks++;
      if (cnt[0] !== 2'd0 || ov[0] !== 1'b0 || od[0] !== 8'h00) begin
         errors++;
         $display("FAIL flush_empty got cnt=%0d v=%b data=%h exp cnt=0 v=0 data=00", cnt[0], ov[0], od[0]);
      end
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (act_vec(k) !== exp_vec(k)) begin
            errors++;
            $display("FAIL flush_vec dut%0d got=%h exp=%h", k, act_vec(k), exp_vec(k));
         end
      end
      seen[0].delete(); seen[1].delete();
      out_ready = 1;
      #1; cyc(); cyc(); cyc();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (seen[k].size() != 0) begin
            errors++;
            $display("FAIL flush_leak dut%0d got=%0d items exp=0 first=%h", k, seen[k].size(), seen[k][0]);
         end
      end
   endtask

   task automatic test_bypass();
      in_valid = 1; out_ready = 1; in_data = 8'h77;
      #1;
      checks++;
      if ({ov[0], od[0]} !== {BYP, BYP ? 8'h77 : 8'h00}) begin
         errors++;
         $display("FAIL bypass_same_cycle got v=%b data=%h exp v=%b data=%h", ov[0], od[0], BYP, BYP ? 8'h77 : 8'h00);
      end
      cyc();
      in_valid = 0;
      #1;
      checks++;
      if ({cnt[0], od[0]} !== {BYP ? 2'd0 : 2'd1, BYP ? 8'h00 : 8'h77}) begin
         errors++;
         $display("FAIL bypass_next_cycle got cnt=%0d data=%h exp cnt=%0d data=%h",
                  cnt[0], od[0], BYP ? 0 : 1, BYP ? 8'h00 : 8'h77);
      end
      cyc();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst       = ($urandom_range(0, 63) == 0);
         flush     = ($urandom_range(0, 15) == 0);
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         #1;
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (act_vec(k) !== exp_vec(k)) begin
               errors++;
               $display("FAIL random_vec dut%0d cyc%0d got=%h exp=%h", k, c, act_vec(k), exp_vec(k));
            end
         end
         cyc();
      end
      rst = 0; flush = 0; in_valid = 0;
   endtask

   initial begin
      rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
      test_reset();
      test_fill_drain();
      test_stream();
      test_wrap();
      test_flush();
      test_bypass();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
